// File: rtl/adc_spi_responder.sv
// adc_spi_responder: emulates an 8-channel 12-bit SAR ADC behind an SPI-style
// CONVST/SCK/SDI/SDO interface. All inputs are oversampled in the sys_clk domain.
module adc_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CONV_CYCLES = 64
) (
  input  logic         sys_clk,
  input  logic         reset_n,
  input  logic [255:0] sample_channels,
  input  logic         ADC_CONVST,
  input  logic         ADC_SCK,
  input  logic         ADC_SDI,
  output logic         ADC_SDO,
  output logic         busy,
  output logic [2:0]   active_channel,
  output logic         frame_done,
  output logic         err_early
);

  localparam int unsigned CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] convst_sync_q, sck_sync_q, sdi_sync_q;
  logic                   convst_prev_q, sck_prev_q;
  logic                   convst_s, sck_s, sdi_s;
  logic                   conv_rise, conv_fall, sck_rise, sck_fall;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [11:0]     conv_q, conv_d;
  logic [11:0]     shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      cfg_cnt_q, cfg_cnt_d;
  logic [3:0]      cfg_q, cfg_d;     // last four config bits; S/D and SLP never needed
  logic [2:0]      chan_q, chan_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            sdo_d, busy_d, frame_done_d, err_early_d;

  // Input synchronizers plus one extra stage for edge detection
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      convst_sync_q <= '0;
      sck_sync_q    <= '0;
      sdi_sync_q    <= '0;
      convst_prev_q <= 1'b0;
      sck_prev_q    <= 1'b0;
    end else begin
      convst_sync_q <= {convst_sync_q[SYNC_STAGES-2:0], ADC_CONVST};
      sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], ADC_SCK};
      sdi_sync_q    <= {sdi_sync_q[SYNC_STAGES-2:0], ADC_SDI};
      convst_prev_q <= convst_sync_q[SYNC_STAGES-1];
      sck_prev_q    <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign convst_s  = convst_sync_q[SYNC_STAGES-1];
  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign conv_rise = convst_s & ~convst_prev_q;
  assign conv_fall = ~convst_s & convst_prev_q;
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      conv_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cfg_cnt_q <= '0;
      cfg_q     <= '0;
      chan_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      conv_q    <= conv_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cfg_cnt_q <= cfg_cnt_d;
      cfg_q     <= cfg_d;
      chan_q    <= chan_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; a CONVST rise preempts everything else in every state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    conv_d    = conv_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cfg_cnt_d = cfg_cnt_q;
    cfg_d     = cfg_q;
    chan_d    = chan_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (conv_rise) begin
      conv_d  = sample_channels[{chan_q, 5'b0} +: 12];
      cnt_d   = CNT_LOAD;
      state_d = CONVERT;
    end else begin
      unique case (state_q)
        CONVERT: begin
          if (conv_fall) begin
            // A fall on the final count is a normal completion, not early
            err_d     = (cnt_q != '0);
            shift_d   = conv_q;
            bit_cnt_d = '0;
            cfg_cnt_d = '0;
            state_d   = SHIFT;
          end else if (cnt_q == '0) begin
            state_d = READY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        READY: begin
          if (conv_fall) begin
            shift_d   = conv_q;
            bit_cnt_d = '0;
            cfg_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (!conv_fall) begin
            if (sck_rise && (cfg_cnt_q < 3'd6)) begin
              cfg_d     = {cfg_q[2:0], sdi_s};
              cfg_cnt_d = cfg_cnt_q + 3'd1;
              // cfg_q now holds O/S, S1, S0, UNI; the 6th bit (SLP) is dropped
              if (cfg_cnt_q == 3'd5) chan_d = {cfg_q[2], cfg_q[1], cfg_q[3]};
            end
            if (sck_fall) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd11) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state
  always_comb begin
    sdo_d        = (state_q == SHIFT) ? shift_q[4'd11 - bit_cnt_q] : 1'b0;
    busy_d       = (state_q == CONVERT);
    frame_done_d = done_q;
    err_early_d  = err_q;
  end

  // Output registers
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ADC_SDO    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_early  <= 1'b0;
    end else begin
      ADC_SDO    <= sdo_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      err_early  <= err_early_d;
    end
  end

  assign active_channel = chan_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed testbench for adc_spi_responder acting as a simple SPI controller.
module tb_adc_spi_responder;

  localparam int unsigned HALF = 10;
  localparam int unsigned CONV = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         convst = 1'b0;
  logic         sck = 1'b0;
  logic         sdi = 1'b0;
  logic [255:0] lanes;
  logic         sdo, busy, fd, err;
  logic [2:0]   ach;

  int unsigned  n_tests = 0;
  int unsigned  n_fail = 0;
  int unsigned  fd_cnt = 0;
  int unsigned  err_cnt = 0;
  int unsigned  fd_before;
  int unsigned  prev;
  logic [11:0]  rx;

  adc_spi_responder #(.SYNC_STAGES(2), .CONV_CYCLES(CONV)) dut (
    .sys_clk(clk),
    .reset_n(rst_n),
    .sample_channels(lanes),
    .ADC_CONVST(convst),
    .ADC_SCK(sck),
    .ADC_SDI(sdi),
    .ADC_SDO(sdo),
    .busy(busy),
    .active_channel(ach),
    .frame_done(fd),
    .err_early(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fd)  fd_cnt++;
    if (err) err_cnt++;
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] cfg_for(input int unsigned ch);
    logic [2:0] c;
    c = 3'(ch);
    return {1'b1, c[0], c[2], c[1], 2'b00};
  endfunction

  function automatic logic [31:0] sweep_lane(input int unsigned k);
    return {20'hFFFFF, 12'(32'h100 * k + 32'h5A)};
  endfunction

  // Clock SCK cycles first..last-1; SDO sampled just before each rise
  task automatic shift_bits(input int unsigned first, input int unsigned last,
                            input logic [5:0] cfg);
    for (int unsigned i = first; i < last; i++) begin
      sdi = (i < 6) ? cfg[5-i] : 1'b0;
      cyc(HALF);
      rx[11-i] = sdo;
      sck = 1'b1;
      cyc(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [5:0] cfg);
    convst = 1'b1;
    cyc(CONV + 10);
    convst = 1'b0;
    cyc(HALF);
    shift_bits(0, 12, cfg);
    cyc(HALF);
  endtask

  initial begin
    lanes = '0;
    lanes[31:0]    = 32'h0000_0123;
    lanes[96 +: 32] = 32'h0000_0ABC;
    rx = '0;
    cyc(3);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chan", 32'(ach), 32'd0);
    check("rst_fd", 32'(fd), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // Frame 1: returns channel 0, configures channel 3
    convst = 1'b1;
    cyc(10);
    check("busy_hi", 32'(busy), 32'd1);
    cyc(CONV);
    check("busy_lo", 32'(busy), 32'd0);
    convst = 1'b0;
    cyc(HALF);
    shift_bits(0, 6, 6'b110110);
    cyc(HALF);
    check("cfg_ch3", 32'(ach), 32'd3);
    shift_bits(6, 12, 6'b110110);
    cyc(HALF);
    check("f1_data", 32'(rx), 32'h123);
    check("sdo_idle", 32'(sdo), 32'd0);

    // Frame 2: lane 3 changes mid-conversion; the captured value must survive
    convst = 1'b1;
    cyc(5);
    lanes[96 +: 32] = 32'h0000_0777;
    cyc(CONV + 5);
    convst = 1'b0;
    cyc(HALF);
    shift_bits(0, 12, cfg_for(0));
    cyc(HALF);
    check("f2_data", 32'(rx), 32'hABC);
    check("f2_chan", 32'(ach), 32'd0);

    // Channel sweep with upper lane bits set
    for (int unsigned k = 0; k < 8; k++) lanes[32*k +: 32] = sweep_lane(k);
    prev = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      frame(cfg_for(k));
      check("sweep_data", 32'(rx), 32'h100 * prev + 32'h5A);
      check("sweep_chan", 32'(ach), k);
      prev = k;
    end

    // Early CONVST fall at cycle 10 of the conversion
    convst = 1'b1;
    cyc(10);
    convst = 1'b0;
    cyc(6);
    check("early_err", err_cnt, 32'd1);
    check("early_busy", 32'(busy), 32'd0);
    cyc(HALF);
    shift_bits(0, 12, cfg_for(2));
    cyc(HALF);
    check("early_data", 32'(rx), 32'h75A);

    // Aborted frame after 4 SCK cycles
    fd_before = fd_cnt;
    convst = 1'b1;
    cyc(CONV + 10);
    convst = 1'b0;
    cyc(HALF);
    shift_bits(0, 4, cfg_for(5));
    cyc(HALF);
    check("abort_chan", 32'(ach), 32'd2);
    frame(cfg_for(4));
    check("abort_data", 32'(rx), 32'h25A);
    check("abort_fd", fd_cnt, fd_before + 1);
    check("abort_newchan", 32'(ach), 32'd4);

    // Reset after the 7th SCK fall (SDO is a 1 bit of 0x45A at that point)
    convst = 1'b1;
    cyc(CONV + 10);
    convst = 1'b0;
    cyc(HALF);
    shift_bits(0, 7, cfg_for(6));
    cyc(HALF);
    check("pre_rst_chan", 32'(ach), 32'd6);
    check("pre_rst_sdo", 32'(sdo), 32'd1);
    rst_n = 1'b0;
    cyc(2);
    check("mid_rst_sdo", 32'(sdo), 32'd0);
    check("mid_rst_chan", 32'(ach), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc(3);
    frame(cfg_for(1));
    check("post_rst_data", 32'(rx), 32'h05A);
    check("post_rst_chan", 32'(ach), 32'd1);

    check("fd_total", fd_cnt, 32'd13);
    check("err_total", err_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
